// File: rtl/network_can_oci_pkg.sv
// Shared types and constants for the OCI direct-branch trace (DCT) packer.
package network_can_oci_pkg;

   localparam int DEF_ENTRIES = 15;
   localparam int DEF_CNT_W   = 4;

   localparam logic [1:0] DCT_TAKEN     = 2'b10;
   localparam logic [1:0] DCT_NOT_TAKEN = 2'b01;

   typedef struct packed {
      logic [3:0]  count;
      logic [29:0] buffer;
   } dct_frame_t;

   function automatic logic [1:0] dct_code(input logic taken);
      return taken ? DCT_TAKEN : DCT_NOT_TAKEN;
   endfunction

endpackage

// File: rtl/network_can_oci_frame_reg.sv
// Single-entry valid/ready holding register between the DCT packer and the trace FIFO.
module network_can_oci_frame_reg #(
   parameter int W = 34
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         ready,
   output logic         valid,
   output logic [W-1:0] data,
   output logic         slot_free
);

   assign slot_free = !valid || ready;

   // load is only raised by the owner while slot_free is high, so a load always wins over an accept
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/network_can_oci_dct_packer.sv
// Packs resolved conditional branches into 2-bit DCT entries and hands full/flushed buffers downstream.
// Optional build macro DCT_OVERFLOW_CNT_EN adds a saturating drop_count output.
module network_can_oci_dct_packer
   import network_can_oci_pkg::*;
#(
   parameter int ENTRIES = DEF_ENTRIES,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   trc_on,
   input  logic                   br_valid,
   input  logic                   br_taken,
   input  logic                   flush_req,
   input  logic                   frame_ready,
   output logic                   frame_valid,
   output logic [2*ENTRIES-1:0]   dct_buffer,
   output logic [CNT_W-1:0]       dct_count,
   output logic                   overflow
`ifdef DCT_OVERFLOW_CNT_EN
   ,
   output logic [7:0]             drop_count
`endif
);

   localparam int BUF_W = 2 * ENTRIES;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ENTRIES);

   logic [BUF_W-1:0]       work_buf;
   logic [CNT_W-1:0]       work_cnt;
   logic                   pending_flush;
   logic [BUF_W-1:0]       post_buf;
   logic [CNT_W-1:0]       post_cnt;
   logic                   is_full;
   logic                   do_append;
   logic                   drop;
   logic                   emit;
   logic                   slot_free;
   logic                   load;
   logic [CNT_W+BUF_W-1:0] frame_data;

   assign is_full   = (work_cnt == FULL_CNT);
   assign do_append = trc_on && br_valid && !is_full;
   assign drop      = trc_on && br_valid && is_full;

   // Emission decisions look at the buffer as it will be after this cycle's branch is appended
   assign post_buf = do_append ? {work_buf[BUF_W-3:0], dct_code(br_taken)} : work_buf;
   assign post_cnt = work_cnt + CNT_W'(do_append);

   assign emit = trc_on && ((post_cnt == FULL_CNT) ||
                            ((flush_req || pending_flush) && (post_cnt != '0)));
   assign load = emit && slot_free;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         work_buf      <= '0;
         work_cnt      <= '0;
         pending_flush <= 1'b0;
      end else if (!trc_on || load) begin
         work_buf      <= '0;
         work_cnt      <= '0;
         pending_flush <= 1'b0;
      end else begin
         work_buf <= post_buf;
         work_cnt <= post_cnt;
         if (flush_req && (post_cnt != '0)) begin
            pending_flush <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end
   end

`ifdef DCT_OVERFLOW_CNT_EN
   logic trc_on_d;

   // A fresh trace session (trc_on rising) starts the drop tally from zero
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         trc_on_d   <= 1'b0;
         drop_count <= 8'd0;
      end else begin
         trc_on_d <= trc_on;
         if (trc_on && !trc_on_d) begin
            drop_count <= 8'd0;
         end else if (drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
         end
      end
   end
`endif

   network_can_oci_frame_reg #(
      .W (CNT_W + BUF_W)
   ) u_frame_reg (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (load),
      .load_data ({post_cnt, post_buf}),
      .ready     (frame_ready),
      .valid     (frame_valid),
      .data      (frame_data),
      .slot_free (slot_free)
   );

   assign {dct_count, dct_buffer} = frame_data;

endmodule

// File: tb/tb_network_can_oci_dct_packer.sv
// Self-checking bench for the DCT packer: directed vector table, multi-cycle corner sequences, random vs model.
module tb_network_can_oci_dct_packer;

   logic        clk;
   logic        reset_n;
   logic        trc_on;
   logic        br_valid;
   logic        br_taken;
   logic        flush_req;
   logic        frame_ready;
   logic        frame_valid;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        overflow;
`ifdef DCT_OVERFLOW_CNT_EN
   logic [7:0]  drop_count;
`endif

   network_can_oci_dct_packer dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .trc_on      (trc_on),
      .br_valid    (br_valid),
      .br_taken    (br_taken),
      .flush_req   (flush_req),
      .frame_ready (frame_ready),
      .frame_valid (frame_valid),
      .dct_buffer  (dct_buffer),
      .dct_count   (dct_count),
      .overflow    (overflow)
`ifdef DCT_OVERFLOW_CNT_EN
      ,
      .drop_count  (drop_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: working buffer kept as a list of entry codes, oldest first
   int          wq[$];
   bit          m_pend;
   bit          m_valid;
   logic [29:0] m_buf;
   logic [3:0]  m_cnt;
   bit          m_ovf;
   int          m_drop;
   bit          m_prev_tr;

   typedef struct {
      bit          vl;
      bit          tk;
      bit          fl;
      bit          rdy;
      bit          tr;
      bit          ev;
      logic [3:0]  ec;
      logic [29:0] eb;
   } vec_t;

   vec_t tab[$];

   function automatic logic [29:0] pack_entries();
      logic [29:0] b;
      b = '0;
      foreach (wq[i]) b = b | (30'(wq[i]) << (2 * (wq.size() - 1 - i)));
      return b;
   endfunction

   task automatic model_reset();
      wq.delete();
      m_pend    = 0;
      m_valid   = 0;
      m_buf     = '0;
      m_cnt     = '0;
      m_ovf     = 0;
      m_drop    = 0;
      m_prev_tr = 0;
   endtask

   task automatic model_edge(input bit vl, input bit tk, input bit fl, input bit rdy, input bit tr);
      bit slot_free;
      bit drop;
      bit emit;
      bit loaded;
      slot_free = !m_valid || rdy;
      drop      = tr && vl && (wq.size() == 15);
      loaded    = 0;
      if (tr && vl && wq.size() < 15) wq.push_back(tk ? 2 : 1);
      emit = tr && ((wq.size() == 15) || ((fl || m_pend) && wq.size() > 0));
      if (!tr) begin
         wq.delete();
         m_pend = 0;
      end else if (emit && slot_free) begin
         m_buf  = pack_entries();
         m_cnt  = 4'(wq.size());
         loaded = 1;
         wq.delete();
         m_pend = 0;
      end else if (fl && wq.size() > 0) begin
         m_pend = 1;
      end
      if (loaded) m_valid = 1;
      else if (rdy) m_valid = 0;
      if (drop) m_ovf = 1;
      if (tr && !m_prev_tr) m_drop = 0;
      else if (drop && m_drop < 255) m_drop++;
      m_prev_tr = tr;
   endtask

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input bit vl, input bit tk, input bit fl, input bit rdy, input bit tr);
      br_valid    = vl;
      br_taken    = tk;
      flush_req   = fl;
      frame_ready = rdy;
      trc_on      = tr;
      @(posedge clk);
      model_edge(vl, tk, fl, rdy, tr);
      #1;
   endtask

   task automatic checkOutput(input string tag, input bit ev, input logic [3:0] ec,
                              input logic [29:0] eb, input bit eo, input bit chk_data);
      cmp({tag, ".frame_valid"}, 64'(frame_valid), 64'(ev));
      if (chk_data) begin
         cmp({tag, ".dct_count"}, 64'(dct_count), 64'(ec));
         cmp({tag, ".dct_buffer"}, 64'(dct_buffer), 64'(eb));
      end
      cmp({tag, ".overflow"}, 64'(overflow), 64'(eo));
   endtask

   task automatic check_model(input string tag);
      checkOutput(tag, m_valid, m_cnt, m_buf, m_ovf, 1'b1);
`ifdef DCT_OVERFLOW_CNT_EN
      cmp({tag, ".drop_count"}, 64'(drop_count), 64'(m_drop));
`endif
   endtask

   task automatic do_reset();
      br_valid  = 0;
      br_taken  = 0;
      flush_req = 0;
      frame_ready = 0;
      trc_on    = 0;
      reset_n   = 0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1;
   endtask

   task automatic add_vec(input bit vl, input bit tk, input bit fl, input bit rdy, input bit tr,
                          input bit ev, input logic [3:0] ec, input logic [29:0] eb);
      vec_t v;
      v.vl = vl; v.tk = tk; v.fl = fl; v.rdy = rdy; v.tr = tr;
      v.ev = ev; v.ec = ec; v.eb = eb;
      tab.push_back(v);
   endtask

   initial begin
      // Directed table: full frame, flushes, empty flush, trace-off discard
      for (int i = 0; i < 15; i++) add_vec(1, (i % 2) == 0, 0, 1, 1, i == 14, 4'd15, 30'h26666666);
      add_vec(0, 0, 0, 1, 1, 0, 0, 0);
      add_vec(1, 1, 0, 1, 1, 0, 0, 0);
      add_vec(1, 1, 0, 1, 1, 0, 0, 0);
      add_vec(1, 1, 1, 1, 1, 1, 4'd3, 30'h0000002A);
      add_vec(0, 0, 0, 1, 1, 0, 0, 0);
      add_vec(1, 0, 1, 1, 1, 1, 4'd1, 30'h00000001);
      add_vec(0, 0, 0, 1, 1, 0, 0, 0);
      add_vec(0, 0, 1, 1, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) add_vec(0, 0, 0, 1, 1, 0, 0, 0);
      add_vec(1, 1, 0, 1, 1, 0, 0, 0);
      add_vec(0, 0, 1, 1, 1, 1, 4'd1, 30'h00000002);
      add_vec(0, 0, 0, 1, 1, 0, 0, 0);
      add_vec(1, 1, 0, 1, 1, 0, 0, 0);
      add_vec(1, 0, 0, 1, 1, 0, 0, 0);
      add_vec(1, 1, 0, 1, 0, 0, 0, 0);
      add_vec(0, 0, 1, 1, 1, 0, 0, 0);
      add_vec(0, 0, 0, 1, 1, 0, 0, 0);

      do_reset();
      checkOutput("reset", 0, 4'd0, 30'd0, 0, 1'b1);
`ifdef DCT_OVERFLOW_CNT_EN
      cmp("reset.drop_count", 64'(drop_count), 64'd0);
`endif

      for (int i = 0; i < tab.size(); i++) begin
         applyStimulus(tab[i].vl, tab[i].tk, tab[i].fl, tab[i].rdy, tab[i].tr);
         checkOutput($sformatf("vec%0d", i), tab[i].ev, tab[i].ec, tab[i].eb, 0, tab[i].ev);
      end

      // Stalled downstream: first frame held, second fills, 31st branch dropped
      for (int i = 0; i < 15; i++) applyStimulus(1, 1, 0, 0, 1);
      checkOutput("stall.first", 1, 4'd15, 30'h2AAAAAAA, 0, 1'b1);
      for (int i = 0; i < 15; i++) applyStimulus(1, 0, 0, 0, 1);
      checkOutput("stall.held", 1, 4'd15, 30'h2AAAAAAA, 0, 1'b1);
      applyStimulus(1, 0, 0, 0, 1);
      checkOutput("stall.drop", 1, 4'd15, 30'h2AAAAAAA, 1, 1'b1);
`ifdef DCT_OVERFLOW_CNT_EN
      cmp("stall.drop_count", 64'(drop_count), 64'd1);
`endif
      applyStimulus(0, 0, 0, 1, 1);
      checkOutput("stall.second", 1, 4'd15, 30'h15555555, 1, 1'b1);
      applyStimulus(0, 0, 0, 1, 1);
      checkOutput("stall.drain", 0, 4'd0, 30'd0, 1, 1'b0);

      // Asynchronous reset in the middle of a partial buffer
      for (int i = 0; i < 7; i++) applyStimulus(1, 0, 0, 1, 1);
      #2;
      reset_n = 0;
      model_reset();
      #1;
      checkOutput("rst_async", 0, 4'd0, 30'd0, 0, 1'b1);
`ifdef DCT_OVERFLOW_CNT_EN
      cmp("rst_async.drop_count", 64'(drop_count), 64'd0);
`endif
      @(posedge clk);
      @(negedge clk);
      reset_n = 1;
      for (int i = 0; i < 14; i++) applyStimulus(1, 1, 0, 1, 1);
      checkOutput("rst_fresh.partial", 0, 4'd0, 30'd0, 0, 1'b0);
      applyStimulus(1, 1, 0, 1, 1);
      checkOutput("rst_fresh.full", 1, 4'd15, 30'h2AAAAAAA, 0, 1'b1);

      // Randomized traffic against the reference model
      do_reset();
      for (int i = 0; i < 800; i++) begin
         applyStimulus($urandom_range(99) < 70, $urandom_range(1) == 1, $urandom_range(99) < 10,
                       $urandom_range(99) < 40, $urandom_range(99) < 95);
         check_model($sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/network_can_oci_dct_packer.md
Name: network_can_oci_dct_packer

Overview:
- Upstream neighbour of the OCI trace test-bench monitor; it produces the dct_buffer/dct_count pair that the monitor consumes.
- Packs resolved conditional-branch outcomes from the Nios II pipeline into 2-bit direct-branch trace (DCT) entries, up to 15 per 30-bit buffer.
- Hands completed buffers to the OCI trace FIFO as frames over a valid/ready handshake.
- Emits a frame when the buffer is full or when a flush is requested (indirect jump, exception, trace stop).

Parameters:
- ENTRIES, 15, maximum DCT entries per buffer; buffer width = 2*ENTRIES = 30.
- CNT_W, 4, width of dct_count; must hold ENTRIES.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- trc_on  in  1  trace enable; low clears the working buffer.
- br_valid  in  1  one conditional branch resolved this cycle.
- br_taken  in  1  outcome qualifier for br_valid.
- flush_req  in  1  force emission of a partial buffer.
- frame_ready  in  1  downstream accepts a frame.
- frame_valid  out  1  frame register holds a frame.
- dct_buffer  out  30  frame payload; newest entry in bits [1:0].
- dct_count  out  4  number of valid entries in dct_buffer (1..15).
- overflow  out  1  sticky; an event was dropped.

Behaviour:
- Reset (async, reset_n=0):
  - Working buffer and working count = 0; pending flush flag = 0.
  - frame_valid = 0, dct_buffer = 0, dct_count = 0, overflow = 0.
- Entry encoding:
  - Taken = 2'b10; not-taken = 2'b01.
  - 2'b00 never written; 2'b11 reserved.
- Append: on br_valid with trc_on=1 and working count < 15:
  - work_buf <= {work_buf[27:0], code}; work_cnt <= work_cnt+1.
- Frame slot free when frame_valid=0, or frame_valid=1 and frame_ready=1 in the same cycle.
- Emit condition, any one of:
  - work_cnt == 15 (including the entry appended this cycle);
  - flush_req=1 or pending_flush=1, with work_cnt (after append) > 0.
- Emit with slot free:
  - Next edge: dct_buffer/dct_count load the post-append working values; frame_valid=1.
  - Working buffer and count clear to 0; pending_flush clears.
  - Latency: frame_valid asserted exactly 1 cycle after the 15th br_valid.
- Emit with slot busy:
  - Working state holds; a flush sets pending_flush.
  - Transfer happens on the first edge where the slot is free.
- Simultaneous br_valid and flush_req: the branch is appended first, then the combined buffer is emitted.
- flush_req with work_cnt==0 and no branch: no frame, no pending flag.
- Full and stalled (work_cnt==15, slot busy): a further br_valid is dropped and overflow <= 1, held until reset.
- Handshake:
  - Frame register stable while frame_valid=1 and frame_ready=0.
  - frame_valid drops the cycle after acceptance unless a new frame loads on that same edge.
- trc_on=0:
  - br_valid ignored; working buffer, count and pending_flush clear next edge.
  - A frame already in the frame register is still delivered.
- reset_n asserted mid-frame: all state cleared immediately; partial data discarded.

Optional Feature:
- Macro: DCT_OVERFLOW_CNT_EN.
- Defined:
  - Adds output drop_count[7:0], reset 0.
  - Increments on every dropped br_valid; saturates at 255.
  - Clears when trc_on rises 0->1.
- Undefined: port and counter absent; only the sticky overflow flag exists.

Decomposition:
- Shared package network_can_oci_pkg:
  - DCT_TAKEN and DCT_NOT_TAKEN entry codes;
  - ENTRIES/CNT_W defaults;
  - dct_frame_t struct {count[3:0], buffer[29:0]}.
- One natural sub-module, network_can_oci_frame_reg: single-entry valid/ready holding register with load/accept logic.
- The packer instantiates network_can_oci_frame_reg.

Test Plan:
- 15 consecutive br_valid, taken alternating starting taken, frame_ready=1 -> one cycle after the 15th: frame_valid=1, dct_count=15, dct_buffer=30'h26666666 (sequence 10,01,10,…,10, newest in [1:0]).
- 3 taken branches then flush_req, ready=1 -> next cycle: dct_count=3, dct_buffer=30'h0000002A.
- br_valid(not-taken) and flush_req in the same cycle on an empty buffer -> dct_count=1, dct_buffer=30'h1.
- frame_ready=0, 30 branches issued, then a 31st -> first frame held stable; second buffer full; overflow=1; with DCT_OVERFLOW_CNT_EN, drop_count=1; after ready=1, the second frame follows.
- flush_req with empty buffer -> frame_valid stays 0 for 5 cycles.
- reset_n pulsed low after 7 branches -> outputs 0 immediately; the next 15 branches form a fresh frame with dct_count=15.
